// File: rtl/systolic_frame_io.sv
// Lane-serial frame deserialiser/serialiser with accumulator bank for a systolic cell.
// Frames of BEATS beats are decoded at the boundary beat into PASS, AB or XCHG.
module systolic_frame_io #(
    parameter int LANE_W  = 4,
    parameter int BEATS   = 4,
    parameter int NUM_ACC = 4,
    localparam int WORD_W = LANE_W * BEATS,
    localparam int BW     = $clog2(BEATS),
    localparam int IW     = $clog2(NUM_ACC)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [LANE_W-1:0] col_in,
    input  logic              col_ctrl_in,
    input  logic [LANE_W-1:0] row_in,
    input  logic              row_ctrl_in,
    output logic [LANE_W-1:0] col_out,
    output logic              col_ctrl_out,
    output logic [LANE_W-1:0] row_out,
    output logic              row_ctrl_out,
    output logic              out_oe,
    output logic [BW-1:0]     beat,
    output logic              ab_valid,
    output logic [WORD_W-1:0] col_word,
    output logic [WORD_W-1:0] row_word,
    output logic              col_fmt,
    output logic              row_fmt,
    input  logic              wb_valid,
    input  logic [IW-1:0]     wb_idx,
    input  logic [WORD_W-1:0] wb_data,
    input  logic [IW-1:0]     acc_rd_idx,
    output logic [WORD_W-1:0] acc_rd_data
);
    localparam int P_W  = (IW > 1) ? IW - 1 : 1;
    localparam int SH_W = WORD_W - LANE_W;
    localparam int CW   = BEATS - 1;

    logic [BW-1:0]     beat_q, beat_d;
    logic [SH_W-1:0]   col_sh_q, col_sh_d, row_sh_q, row_sh_d;
    logic [CW-1:0]     cc_sh_q, cc_sh_d, rc_sh_q, rc_sh_d;
    logic [WORD_W-1:0] col_ob_q, col_ob_d, row_ob_q, row_ob_d;
    logic [BEATS-1:0]  cc_ob_q, cc_ob_d, rc_ob_q, rc_ob_d;
    logic [WORD_W-1:0] acc_q [NUM_ACC];
    logic [WORD_W-1:0] acc_d [NUM_ACC];

    logic [BEATS-1:0]  col_ctrl_word, row_ctrl_word;
    logic              boundary, xchg;
    logic [P_W-1:0]    pair;
    logic [IW-1:0]     lo_idx, hi_idx;
    logic [WORD_W-1:0] xo_col, xo_row;

    assign boundary      = (beat_q == BW'(BEATS - 1));
    assign col_word      = {col_sh_q, col_in};
    assign row_word      = {row_sh_q, row_in};
    assign col_ctrl_word = {cc_sh_q, col_ctrl_in};
    assign row_ctrl_word = {rc_sh_q, row_ctrl_in};

    assign xchg     = boundary && col_ctrl_word[BEATS-1] && !row_ctrl_word[BEATS-1];
    assign ab_valid = boundary && !col_ctrl_word[BEATS-1] && row_ctrl_word[BEATS-1];
    assign pair     = col_ctrl_word[BEATS-2 -: P_W];
    assign lo_idx   = IW'(pair) << 1;
    assign hi_idx   = lo_idx | IW'(1);

    assign col_out      = col_ob_q[WORD_W-1 -: LANE_W];
    assign row_out      = row_ob_q[WORD_W-1 -: LANE_W];
    assign col_ctrl_out = cc_ob_q[BEATS-1];
    assign row_ctrl_out = rc_ob_q[BEATS-1];
    assign out_oe       = rst_n;
    assign beat         = beat_q;
    assign col_fmt      = col_ctrl_word[BEATS-2];
    assign row_fmt      = row_ctrl_word[BEATS-2];
    assign acc_rd_data  = acc_q[acc_rd_idx];

    always_comb begin
        beat_d   = beat_q;
        col_sh_d = col_sh_q;
        row_sh_d = row_sh_q;
        cc_sh_d  = cc_sh_q;
        rc_sh_d  = rc_sh_q;
        col_ob_d = col_ob_q;
        row_ob_d = row_ob_q;
        cc_ob_d  = cc_ob_q;
        rc_ob_d  = rc_ob_q;
        acc_d    = acc_q;
        // a same-cycle writeback is forwarded into the outgoing exchange word
        xo_col   = acc_q[lo_idx];
        xo_row   = acc_q[hi_idx];
        if (wb_valid && wb_idx == lo_idx) xo_col = wb_data;
        if (wb_valid && wb_idx == hi_idx) xo_row = wb_data;
        if (ena) begin
            beat_d   = beat_q + BW'(1);
            col_sh_d = SH_W'({col_sh_q, col_in});
            row_sh_d = SH_W'({row_sh_q, row_in});
            cc_sh_d  = CW'({cc_sh_q, col_ctrl_in});
            rc_sh_d  = CW'({rc_sh_q, row_ctrl_in});
            if (boundary) begin
                col_ob_d = xchg ? xo_col : col_word;
                row_ob_d = xchg ? xo_row : row_word;
                cc_ob_d  = col_ctrl_word;
                rc_ob_d  = row_ctrl_word;
            end else begin
                col_ob_d = col_ob_q << LANE_W;
                row_ob_d = row_ob_q << LANE_W;
                cc_ob_d  = cc_ob_q << 1;
                rc_ob_d  = rc_ob_q << 1;
            end
            if (wb_valid) acc_d[wb_idx] = wb_data;
            // exchange store overrides a colliding writeback
            if (xchg) begin
                acc_d[lo_idx] = col_word;
                acc_d[hi_idx] = row_word;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_q   <= '0;
            col_sh_q <= '0;
            row_sh_q <= '0;
            cc_sh_q  <= '0;
            rc_sh_q  <= '0;
            col_ob_q <= '0;
            row_ob_q <= '0;
            cc_ob_q  <= '0;
            rc_ob_q  <= '0;
            for (int i = 0; i < NUM_ACC; i++) acc_q[i] <= '0;
        end else begin
            beat_q   <= beat_d;
            col_sh_q <= col_sh_d;
            row_sh_q <= row_sh_d;
            cc_sh_q  <= cc_sh_d;
            rc_sh_q  <= rc_sh_d;
            col_ob_q <= col_ob_d;
            row_ob_q <= row_ob_d;
            cc_ob_q  <= cc_ob_d;
            rc_ob_q  <= rc_ob_d;
            acc_q    <= acc_d;
        end
    end
endmodule

// File: tb/tb_systolic_frame_io.sv
// Scoreboard bench for systolic_frame_io in the 4/4/4 and 2/8/8 configurations.
// Each frame pushes a record; the monitors check it at that frame's boundary beat.
module tb_systolic_frame_io;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] ic, ir, oc, orw, aval;
        logic [7:0]  occ, orc;
        logic        ab, cf, rf;
    } rec_t;

    rec_t q4[$];
    rec_t q8[$];
    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    logic        ena4, cci4, rci4, wbv4;
    logic [3:0]  coli4, rowi4, colo4, rowo4;
    logic [1:0]  wbi4, rdi4, beat4;
    logic [15:0] wbd4, cw4, rw4, rd4;
    logic        cco4, rco4, oe4, ab4, cf4, rf4;

    systolic_frame_io #(.LANE_W(4), .BEATS(4), .NUM_ACC(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .ena(ena4),
        .col_in(coli4), .col_ctrl_in(cci4), .row_in(rowi4), .row_ctrl_in(rci4),
        .col_out(colo4), .col_ctrl_out(cco4), .row_out(rowo4), .row_ctrl_out(rco4),
        .out_oe(oe4), .beat(beat4), .ab_valid(ab4),
        .col_word(cw4), .row_word(rw4), .col_fmt(cf4), .row_fmt(rf4),
        .wb_valid(wbv4), .wb_idx(wbi4), .wb_data(wbd4),
        .acc_rd_idx(rdi4), .acc_rd_data(rd4)
    );

    logic        ena8, cci8, rci8, wbv8;
    logic [1:0]  coli8, rowi8, colo8, rowo8;
    logic [2:0]  wbi8, rdi8, beat8;
    logic [15:0] wbd8, cw8, rw8, rd8;
    logic        cco8, rco8, oe8, ab8, cf8, rf8;

    systolic_frame_io #(.LANE_W(2), .BEATS(8), .NUM_ACC(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .ena(ena8),
        .col_in(coli8), .col_ctrl_in(cci8), .row_in(rowi8), .row_ctrl_in(rci8),
        .col_out(colo8), .col_ctrl_out(cco8), .row_out(rowo8), .row_ctrl_out(rco8),
        .out_oe(oe8), .beat(beat8), .ab_valid(ab8),
        .col_word(cw8), .row_word(rw8), .col_fmt(cf8), .row_fmt(rf8),
        .wb_valid(wbv8), .wb_idx(wbi8), .wb_data(wbd8),
        .acc_rd_idx(rdi8), .acc_rd_data(rd8)
    );

    // monitors: gather serial outputs over enabled beats, check at the boundary
    logic [15:0] mc4 = '0, mr4 = '0, mc8 = '0, mr8 = '0;
    logic [3:0]  mcc4 = '0, mrc4 = '0;
    logic [7:0]  mcc8 = '0, mrc8 = '0;
    logic        ae4 = 1'b0, ae8 = 1'b0;

    initial forever begin
        @(negedge clk);
        if (rst_n && ena4) begin
            mc4  = {mc4[11:0], colo4};
            mr4  = {mr4[11:0], rowo4};
            mcc4 = {mcc4[2:0], cco4};
            mrc4 = {mrc4[2:0], rco4};
            if (beat4 != 2'd3) begin
                if (ab4) ae4 = 1'b1;
            end else begin
                if (q4.size() > 0) begin
                    rec_t r;
                    r = q4.pop_front();
                    chk("a4_col_word", cw4, r.ic);
                    chk("a4_row_word", rw4, r.ir);
                    chk("a4_ab_valid", ab4, r.ab);
                    chk("a4_ab_early", ae4, 0);
                    chk("a4_col_fmt", cf4, r.cf);
                    chk("a4_row_fmt", rf4, r.rf);
                    chk("a4_col_out", mc4, r.oc);
                    chk("a4_row_out", mr4, r.orw);
                    chk("a4_col_ctrl_out", mcc4, r.occ[3:0]);
                    chk("a4_row_ctrl_out", mrc4, r.orc[3:0]);
                    chk("a4_acc_rd", rd4, r.aval);
                end
                ae4 = 1'b0;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst_n && ena8) begin
            mc8  = {mc8[13:0], colo8};
            mr8  = {mr8[13:0], rowo8};
            mcc8 = {mcc8[6:0], cco8};
            mrc8 = {mrc8[6:0], rco8};
            if (beat8 != 3'd7) begin
                if (ab8) ae8 = 1'b1;
            end else begin
                if (q8.size() > 0) begin
                    rec_t r;
                    r = q8.pop_front();
                    chk("b8_col_word", cw8, r.ic);
                    chk("b8_row_word", rw8, r.ir);
                    chk("b8_ab_valid", ab8, r.ab);
                    chk("b8_ab_early", ae8, 0);
                    chk("b8_col_fmt", cf8, r.cf);
                    chk("b8_row_fmt", rf8, r.rf);
                    chk("b8_col_out", mc8, r.oc);
                    chk("b8_row_out", mr8, r.orw);
                    chk("b8_col_ctrl_out", mcc8, r.occ);
                    chk("b8_row_ctrl_out", mrc8, r.orc);
                    chk("b8_acc_rd", rd8, r.aval);
                end
                ae8 = 1'b0;
            end
        end
    end

    task automatic f4(input logic [15:0] cw, rw, input logic [3:0] cc, rc, input logic ab,
                      input logic [15:0] oc, orw, input logic [3:0] occ, orc,
                      input int ai, input logic [15:0] av,
                      input int wbb, input logic [1:0] wi, input logic [15:0] wd);
        rec_t r;
        r.ic = cw; r.ir = rw; r.ab = ab; r.cf = cc[2]; r.rf = rc[2];
        r.oc = oc; r.orw = orw; r.occ = {4'h0, occ}; r.orc = {4'h0, orc}; r.aval = av;
        q4.push_back(r);
        rdi4 = 2'(ai);
        for (int k = 0; k < 4; k++) begin
            coli4 = cw[15-4*k -: 4];
            rowi4 = rw[15-4*k -: 4];
            cci4  = cc[3-k];
            rci4  = rc[3-k];
            wbv4  = (k == wbb);
            wbi4  = wi;
            wbd4  = wd;
            @(posedge clk); #1;
        end
        wbv4 = 1'b0;
    endtask

    task automatic f8(input logic [15:0] cw, rw, input logic [7:0] cc, rc,
                      input logic [15:0] oc, orw, input logic [7:0] occ, orc,
                      input int ai, input logic [15:0] av, input int stall);
        rec_t r;
        r.ic = cw; r.ir = rw; r.ab = 1'b0; r.cf = cc[6]; r.rf = rc[6];
        r.oc = oc; r.orw = orw; r.occ = occ; r.orc = orc; r.aval = av;
        q8.push_back(r);
        rdi8 = 3'(ai);
        for (int k = 0; k < 8; k++) begin
            if (k == 4 && stall > 0) begin
                ena8 = 1'b0;
                wbv8 = 1'b1; wbi8 = 3'd0; wbd8 = 16'hFFFF;
                coli8 = 2'b11; rowi8 = 2'b11; cci8 = 1'b1; rci8 = 1'b1;
                repeat (stall) begin @(posedge clk); #1; end
                ena8 = 1'b1;
                wbv8 = 1'b0;
            end
            coli8 = cw[15-2*k -: 2];
            rowi8 = rw[15-2*k -: 2];
            cci8  = cc[7-k];
            rci8  = rc[7-k];
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        ena4 = 0; cci4 = 0; rci4 = 0; wbv4 = 0; coli4 = 0; rowi4 = 0;
        wbi4 = 0; rdi4 = 0; wbd4 = 0;
        ena8 = 0; cci8 = 0; rci8 = 0; wbv8 = 0; coli8 = 0; rowi8 = 0;
        wbi8 = 0; rdi8 = 0; wbd8 = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        ena4 = 1'b1;
        coli4 = 4'h5; rowi4 = 4'h6; cci4 = 1'b1; rci4 = 1'b1;
        repeat (6) begin @(posedge clk); #1; end
        chk("pre_rst_beat", beat4, 2);
        chk("pre_rst_col_out", colo4, 4'h5);
        chk("pre_rst_row_out", rowo4, 4'h6);
        chk("pre_rst_ctrl_out", cco4, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_beat", beat4, 0);
        chk("rst_col_out", colo4, 0);
        chk("rst_row_out", rowo4, 0);
        chk("rst_col_ctrl_out", cco4, 0);
        chk("rst_row_ctrl_out", rco4, 0);
        chk("rst_out_oe", oe4, 0);
        coli4 = 0; rowi4 = 0; cci4 = 0; rci4 = 0;
        rst_n = 1'b1;
        #1;
        chk("rel_out_oe", oe4, 1);
        @(posedge clk); #1;
        chk("rel_first_beat", beat4, 1);
        repeat (3) begin @(posedge clk); #1; end

        f4(16'h1234, 16'hABCD, 4'h0, 4'h0, 1'b0, 16'h0000, 16'h0000, 4'h0, 4'h0, 0, 16'h0000, -1, 2'd0, 16'h0);
        f4(16'h1234, 16'h5678, 4'hC, 4'h0, 1'b0, 16'h1234, 16'hABCD, 4'h0, 4'h0, 2, 16'h0000, -1, 2'd0, 16'h0);
        f4(16'h9999, 16'h8888, 4'hC, 4'h0, 1'b0, 16'h0000, 16'h0000, 4'hC, 4'h0, 2, 16'h1234, -1, 2'd0, 16'h0);
        f4(16'hABCD, 16'h4321, 4'h4, 4'h8, 1'b1, 16'h1234, 16'h5678, 4'hC, 4'h0, 3, 16'h8888, -1, 2'd0, 16'h0);
        f4(16'h7777, 16'h0F0F, 4'h8, 4'h0, 1'b0, 16'hABCD, 16'h4321, 4'h4, 4'h8, 0, 16'h0000, 3, 2'd1, 16'hBEEF);
        f4(16'h0000, 16'h0000, 4'h0, 4'h0, 1'b0, 16'h0000, 16'hBEEF, 4'h8, 4'h0, 1, 16'h0F0F, 1, 2'd2, 16'h5A5A);
        f4(16'h0000, 16'h0000, 4'h0, 4'h0, 1'b0, 16'h0000, 16'h0000, 4'h0, 4'h0, 2, 16'h5A5A, -1, 2'd0, 16'h0);

        ena4 = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        ena8 = 1'b1;
        f8(16'hC3A5, 16'h5A3C, 8'hE0, 8'h00, 16'h0000, 16'h0000, 8'h00, 8'h00, 7, 16'h0000, 0);
        f8(16'h1111, 16'h2222, 8'h00, 8'h00, 16'h0000, 16'h0000, 8'hE0, 8'h00, 6, 16'hC3A5, 3);
        f8(16'h0000, 16'h0000, 8'hE0, 8'h00, 16'h1111, 16'h2222, 8'h00, 8'h00, 7, 16'h5A3C, 0);
        f8(16'h0000, 16'h0000, 8'h00, 8'h00, 16'hC3A5, 16'h5A3C, 8'hE0, 8'h00, 0, 16'h0000, 0);
        f8(16'h0000, 16'h0000, 8'h00, 8'h00, 16'h0000, 16'h0000, 8'h00, 8'h00, 6, 16'h0000, 0);
        ena8 = 1'b0;

        chk("q4_drained", q4.size(), 0);
        chk("q8_drained", q8.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
